systolic_result_collector: RTL and testbench
============================================

Name: systolic_result_collector

Overview:
- Receives the skewed result stream leaving the bottom edge of systolic_array: one value per PE column per cycle, column j lagging column j-1 by one cycle.
- De-skews the stream and saturates each value to WIDTH.
- Assembles a SIZE x SIZE result matrix and raises done when complete; this is the read end of the array's output interface.
- Sits between the array and the NPU result buffer; the matrix is presented in the same A_result[SIZE][SIZE] form used at the array top.

Parameters:
- WIDTH, 16, bit width of each signed output element in A_result.
- ACC_WIDTH, 32, bit width of each signed incoming column value (PE accumulator width).
- SIZE, 10, matrix dimension and number of PE columns.
- TIMEOUT, 64, cycles allowed in COLLECT before timeout is raised.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a new collection; sampled each cycle.
- col_valid  in  [SIZE]  col_valid[j]=1 means col_data[j] holds the next row result of column j.
- col_data  in  [SIZE] x signed ACC_WIDTH  column result values from the array bottom edge.
- busy  out  1  high while in COLLECT.
- done  out  1  high while in DONE; A_result is complete and stable.
- overflow  out  1  sticky: valid seen on an already-full column.
- timeout  out  1  sticky: COLLECT exceeded TIMEOUT cycles.
- A_result  out  [SIZE][SIZE] x signed WIDTH  assembled result matrix.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0; done=0; overflow=0; timeout=0; all A_result elements=0; row counters and cycle counter=0.
- States are IDLE, COLLECT and DONE.
- IDLE:
  - start=1 -> COLLECT.
  - On entry to COLLECT: clear row_cnt[0..SIZE-1], the cycle counter, overflow and timeout. A_result is NOT cleared.
- COLLECT:
  - busy=1; cycle counter increments every cycle.
  - Per column j, independently: if col_valid[j] and row_cnt[j]<SIZE, write sat(col_data[j]) to A_result[row_cnt[j]][j] and increment row_cnt[j].
  - If col_valid[j] and row_cnt[j]==SIZE: drop the data and set overflow.
  - When every row_cnt==SIZE (including counts completed by writes in the current cycle): next state DONE. done rises the cycle after the last write.
  - If the cycle counter reaches TIMEOUT-1 without completion: set timeout and go to DONE with the partial matrix. Unwritten elements keep their old values.
- DONE:
  - done=1, busy=0; A_result is held.
  - Further col_valid pulses set overflow but do not write.
  - start=1 -> COLLECT; done drops in the same transition.
- start while in COLLECT: restarts the collection (counters cleared, timeout/overflow cleared). Data valid in that same cycle is discarded.
- Saturation sat(x): if x > 2^(WIDTH-1)-1, output 2^(WIDTH-1)-1. If x < -2^(WIDTH-1), output -2^(WIDTH-1). Otherwise output x truncated to WIDTH.
- Columns need not be skewed by exactly one cycle; any order and any gaps per column are accepted. Capture order within a column defines the row index.
- Latency: the element written on cycle n is visible on A_result at cycle n+1. done is asserted one cycle after the final write.
- Reset during COLLECT or DONE: returns immediately to IDLE with reset values; the partial matrix is discarded (zeroed).

Test Plan:
- Ideal skew: start, then for t=0..SIZE+SIZE-2 drive col_valid[j]=1 when 0<=t-j<SIZE, data = 100*row+col -> A_result[i][j]=100*i+j for all i,j. done is high exactly at t=19 (cycle after last write), busy falls with it, overflow=0, timeout=0.
- Saturation: column 0 values 40000, -40000, 32767, -32768, 5 -> A_result[0..4][0] = 32767, -32768, 32767, -32768, 5.
- Overflow: complete a full matrix, then pulse col_valid[3] with 999 while in DONE -> overflow=1, A_result unchanged, done remains 1.
- Timeout: start, deliver all rows on columns 0..8 only -> timeout=1 and done=1 at cycle 64 after start. Column 9 rows keep their previous contents; a new start clears timeout.
- Reset mid-collection: assert rst after 5 columns have written 3 rows each -> same cycle, all outputs 0 and state IDLE. A following full ideal-skew run produces the correct matrix.
- Back-to-back: assert start in the DONE cycle and run a second matrix with data = -(10*i+j) -> done drops, then rises again with the new values and no stale elements.

Source files
------------

// File: rtl/systolic_result_collector_if.sv
// systolic_result_collector_if: collector bus; master drives start/col_valid/col_data, slave returns busy/done/overflow/timeout/A_result
interface systolic_result_collector_if #(
  parameter int WIDTH = 16,
  parameter int ACC_WIDTH = 32,
  parameter int SIZE = 10
);
  logic start;
  logic [SIZE-1:0] col_valid;
  logic signed [ACC_WIDTH-1:0] col_data [SIZE];
  logic busy;
  logic done;
  logic overflow;
  logic timeout;
  logic signed [WIDTH-1:0] A_result [SIZE][SIZE];
  modport master (output start, col_valid, col_data, input busy, done, overflow, timeout, A_result);
  modport slave (input start, col_valid, col_data, output busy, done, overflow, timeout, A_result);
endinterface

// File: rtl/systolic_result_collector.sv
// systolic_result_collector: de-skews/saturates array column results into A_result; clk, rst (async), io.slave {start, col_valid, col_data -> busy, done, overflow, timeout, A_result}
module systolic_result_collector #(
  parameter int WIDTH = 16,
  parameter int ACC_WIDTH = 32,
  parameter int SIZE = 10,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  systolic_result_collector_if.slave io
);
  localparam int CW = $clog2(SIZE + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  state_t state;
  logic busy, done, overflow, timeout;
  logic [CW-1:0] row_cnt [SIZE];
  logic [TW-1:0] cyc;
  logic [SIZE-1:0] take, drop, full_nxt;
  logic signed [WIDTH-1:0] a_result [SIZE][SIZE];
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] x);
    return x > SAT_HI ? SAT_HI[WIDTH-1:0] : x < SAT_LO ? SAT_LO[WIDTH-1:0] : x[WIDTH-1:0];
  endfunction
  always_comb begin
    take = '0;
    drop = '0;
    full_nxt = '0;
    for (int j = 0; j < SIZE; j++) begin
      take[j] = io.col_valid[j] && row_cnt[j] < CW'(SIZE);
      drop[j] = io.col_valid[j] && !take[j];
      full_nxt[j] = row_cnt[j] + CW'(take[j]) == CW'(SIZE);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      overflow <= 1'b0;
      timeout <= 1'b0;
      cyc <= '0;
      for (int j = 0; j < SIZE; j++) row_cnt[j] <= '0;
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++) a_result[i][j] <= '0;
    end else if (io.start) begin
      state <= COLLECT;
      busy <= 1'b1;
      done <= 1'b0;
      overflow <= 1'b0;
      timeout <= 1'b0;
      cyc <= '0;
      for (int j = 0; j < SIZE; j++) row_cnt[j] <= '0;
    end else if (state == COLLECT) begin
      cyc <= cyc + TW'(1);
      for (int j = 0; j < SIZE; j++)
        if (take[j]) begin
          a_result[row_cnt[j]][j] <= sat(io.col_data[j]);
          row_cnt[j] <= row_cnt[j] + CW'(1);
        end
      if (|drop) overflow <= 1'b1;
      if (&full_nxt || cyc == TW'(TIMEOUT - 1)) begin
        state <= DONE;
        busy <= 1'b0;
        done <= 1'b1;
        timeout <= !(&full_nxt);
      end
    end else if (state == DONE && |io.col_valid) begin
      overflow <= 1'b1;
    end
  end
  assign io.busy = busy;
  assign io.done = done;
  assign io.overflow = overflow;
  assign io.timeout = timeout;
  assign io.A_result = a_result;
endmodule

// File: tb/tb_systolic_result_collector.sv
// tb_systolic_result_collector: directed + randomized checks of the collector against a spec-level model
module tb_systolic_result_collector;
  localparam int WIDTH = 16;
  localparam int ACC_WIDTH = 32;
  localparam int SIZE = 10;
  localparam int TIMEOUT = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int m_state, m_cyc, m_ovf, m_to;
  int m_cnt [SIZE];
  int m_exp [SIZE][SIZE];
  systolic_result_collector_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .SIZE(SIZE)) io ();
  systolic_result_collector #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .io(io)
  );
  always #5 clk = ~clk;
  function automatic int sat(input longint x);
    longint hi, lo;
    hi = (longint'(1) << (WIDTH - 1)) - 1;
    lo = -hi - 1;
    return x > hi ? int'(hi) : x < lo ? int'(lo) : int'(x);
  endfunction
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_state = 0;
    m_cyc = 0;
    m_ovf = 0;
    m_to = 0;
    for (int j = 0; j < SIZE; j++) m_cnt[j] = 0;
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) m_exp[i][j] = 0;
  endtask
  task automatic model_step();
    int full;
    full = 0;
    if (io.start) begin
      m_state = 1;
      m_cyc = 0;
      m_ovf = 0;
      m_to = 0;
      for (int j = 0; j < SIZE; j++) m_cnt[j] = 0;
    end else if (m_state == 1) begin
      for (int j = 0; j < SIZE; j++)
        if (io.col_valid[j]) begin
          if (m_cnt[j] < SIZE) begin
            m_exp[m_cnt[j]][j] = sat(longint'(io.col_data[j]));
            m_cnt[j]++;
          end else m_ovf = 1;
        end
      for (int j = 0; j < SIZE; j++) full += int'(m_cnt[j] == SIZE);
      if (full == SIZE) m_state = 2;
      else if (m_cyc == TIMEOUT - 1) begin
        m_to = 1;
        m_state = 2;
      end
      m_cyc++;
    end else if (m_state == 2 && io.col_valid != '0) m_ovf = 1;
  endtask
  task automatic check_all(input string tag);
    int bad;
    bad = 0;
    chk({tag, "_busy"}, io.busy, m_state == 1);
    chk({tag, "_done"}, io.done, m_state == 2);
    chk({tag, "_overflow"}, io.overflow, m_ovf != 0);
    chk({tag, "_timeout"}, io.timeout, m_to != 0);
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        if ($signed(io.A_result[i][j]) !== m_exp[i][j]) bad++;
    chk({tag, "_matrix_bad_elems"}, bad, 0);
  endtask
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask
  task automatic clear_inputs();
    io.start = 1'b0;
    io.col_valid = '0;
    for (int j = 0; j < SIZE; j++) io.col_data[j] = '0;
  endtask
  task automatic chk_formula(input int neg, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        if ($signed(io.A_result[i][j]) !== (neg != 0 ? -(10 * i + j) : 100 * i + j)) bad++;
    chk(tag, bad, 0);
  endtask
  task automatic run_ideal(input int neg, input string tag);
    io.start = 1'b1;
    tick({tag, "_start"});
    io.start = 1'b0;
    for (int t = 0; t < 2 * SIZE - 1; t++) begin
      for (int j = 0; j < SIZE; j++) begin
        io.col_valid[j] = t - j >= 0 && t - j < SIZE;
        io.col_data[j] = neg != 0 ? -(10 * (t - j) + j) : 100 * (t - j) + j;
      end
      tick(tag);
      if (t == 2 * SIZE - 3) chk({tag, "_done_early"}, io.done, 1'b0);
    end
    io.col_valid = '0;
    chk({tag, "_done_after_last"}, io.done, 1'b1);
    chk({tag, "_busy_after_last"}, io.busy, 1'b0);
    chk_formula(neg, {tag, "_formula"});
  endtask
  initial begin
    int sat_in [5];
    int sat_out [5];
    int tries;
    sat_in = '{40000, -40000, 32767, -32768, 5};
    sat_out = '{32767, -32768, 32767, -32768, 5};
    clear_inputs();
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;
    run_ideal(0, "ideal");
    tick("done_hold");
    io.col_valid[3] = 1'b1;
    io.col_data[3] = 999;
    tick("ovf");
    chk("ovf_flag", io.overflow, 1'b1);
    chk("ovf_done_kept", io.done, 1'b1);
    io.col_valid = '0;
    tick("ovf_after");
    chk_formula(0, "ovf_unchanged");
    run_ideal(1, "b2b");
    io.start = 1'b1;
    tick("sat_start");
    io.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      io.col_valid = SIZE'(1);
      io.col_data[0] = sat_in[k];
      tick("sat");
    end
    io.col_valid = '0;
    tick("sat_idle");
    for (int k = 0; k < 5; k++) chk("sat_elem", io.A_result[k][0], sat_out[k]);
    io.start = 1'b1;
    io.col_valid = '1;
    for (int j = 0; j < SIZE; j++) io.col_data[j] = 12345;
    tick("to_start");
    io.start = 1'b0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      for (int j = 0; j < SIZE; j++) begin
        io.col_valid[j] = j < SIZE - 1 && k - 1 - j >= 0 && k - 1 - j < SIZE;
        io.col_data[j] = 7 * (k - 1) + j;
      end
      tick("to");
      if (k == TIMEOUT - 1) chk("to_done_early", io.done, 1'b0);
    end
    chk("to_done", io.done, 1'b1);
    chk("to_flag", io.timeout, 1'b1);
    for (int i = 0; i < SIZE; i++) chk("to_col_kept", io.A_result[i][SIZE-1], -(10 * i + SIZE - 1));
    io.col_valid = '0;
    io.start = 1'b1;
    tick("to_restart");
    io.start = 1'b0;
    chk("to_cleared", io.timeout, 1'b0);
    for (int k = 0; k < 3; k++) begin
      io.col_valid = SIZE'(5'b11111);
      for (int j = 0; j < SIZE; j++) io.col_data[j] = int'($urandom_range(0, 2000)) - 1000;
      tick("mid");
    end
    io.col_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid");
    chk("rst_mid_elem", io.A_result[2][4], 0);
    #2;
    rst = 1'b0;
    run_ideal(0, "post_rst");
    for (int r = 0; r < 4; r++) begin
      io.start = 1'b1;
      tick("rnd_start");
      io.start = 1'b0;
      tries = 0;
      while (m_state != 2 && tries < TIMEOUT + 8) begin
        for (int j = 0; j < SIZE; j++) begin
          io.col_valid[j] = $urandom_range(0, 1) != 0;
          io.col_data[j] = $urandom_range(0, 1) != 0 ? 32'($urandom) : int'($urandom_range(0, 80000)) - 40000;
        end
        tick("rnd");
        tries++;
      end
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j < SIZE; j++) io.col_valid[j] = $urandom_range(0, 3) == 0;
        tick("rnd_done");
      end
      io.col_valid = '0;
      chk("rnd_reached_done", io.done, 1'b1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
